// File: rtl/unlock_pkg.sv
// Shared types for the unlock keyer/detector pair: symbol type, FSM states, idle symbol.
package unlock_pkg;

  localparam int unsigned SYM_W = 2;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_GAP
  } state_t;

  localparam sym_t IDLE_SYM_DEF = 2'b00;

  function automatic int unsigned max3(input int unsigned x, input int unsigned y,
                                       input int unsigned z);
    int unsigned m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction

endpackage

// File: rtl/unlock_tmr.sv
// Loadable down-counter with a registered zero flag; saturates at zero.
module unlock_tmr #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic         zero_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else if (load_i) begin
      cnt_q  <= load_val_i;
      zero_q <= (load_val_i == '0);
    end else if (cnt_q != '0) begin
      cnt_q  <= cnt_q - W'(1);
      zero_q <= (cnt_q == W'(1));
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/unlock_keyer.sv
// Transmit side of the unlock pair: sends a programmed code, waits for the unlock
// response, retries after an idle gap, and reports done or fail.
module unlock_keyer
  import unlock_pkg::*;
#(
  parameter int unsigned                 CODE_LEN  = 2,
  parameter logic [SYM_W*CODE_LEN-1:0]   CODE      = 4'b11_01,
  parameter sym_t                        IDLE_SYM  = IDLE_SYM_DEF,
  parameter int unsigned                 HOLD      = 1,
  parameter int unsigned                 TIMEOUT   = 4,
  parameter int unsigned                 GAP       = 2,
  parameter int unsigned                 MAX_TRIES = 3
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               start_i,
  input  logic                               unlock_i,
  output sym_t                               a_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               fail_o,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries_o
);

  localparam int unsigned TMAX = max3(HOLD, TIMEOUT, GAP);
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned IW   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int unsigned RW   = $clog2(MAX_TRIES + 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   tries_q, tries_d;
  sym_t            a_q, a_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            fail_q, fail_d;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_zero;

  unlock_tmr #(.W(TW)) u_tmr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Next state, timer reloads on every phase entry, and next output values.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tries_d  = tries_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    done_d   = 1'b0;
    fail_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_SEND;
          idx_d    = '0;
          tries_d  = RW'(1);
          tmr_load = 1'b1;
          tmr_val  = TW'(HOLD - 1);
        end
      end
      ST_SEND: begin
        if (tmr_zero) begin
          if (idx_q == IW'(CODE_LEN - 1)) begin
            if (unlock_i) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d  = ST_WAIT;
              tmr_load = 1'b1;
              tmr_val  = TW'(TIMEOUT - 1);
            end
          end else begin
            idx_d    = idx_q + IW'(1);
            tmr_load = 1'b1;
            tmr_val  = TW'(HOLD - 1);
          end
        end
      end
      ST_WAIT: begin
        // A response on the expiring edge still counts as success.
        if (unlock_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (tmr_zero) begin
          if (tries_q == RW'(MAX_TRIES)) begin
            state_d = ST_IDLE;
            fail_d  = 1'b1;
          end else begin
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = TW'(GAP - 1);
          end
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          state_d  = ST_SEND;
          idx_d    = '0;
          tries_d  = tries_q + RW'(1);
          tmr_load = 1'b1;
          tmr_val  = TW'(HOLD - 1);
        end
      end
    endcase

    a_d = IDLE_SYM;
    if (state_d == ST_SEND) begin
      a_d = sym_t'(CODE >> (SYM_W * (CODE_LEN - 1 - 32'(idx_d))));
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      tries_q <= '0;
      a_q     <= IDLE_SYM;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tries_q <= tries_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign a_o     = a_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign fail_o  = fail_q;
  assign tries_o = tries_q;

endmodule

// File: tb/tb_unlock_keyer.sv
// Bench for unlock_keyer: directed scenarios plus random traffic on a default and a
// long-hold instance, checked against a timeline model built from attempt arithmetic.
module tb_unlock_keyer;

  logic       clk = 1'b0;
  logic       rst0, st0, ul0, rst1, st1, ul1;
  logic [1:0] a0, a1, tries0, tries1;
  logic       busy0, done0, fail0, busy1, done1, fail1;

  int total = 0;
  int bad   = 0;

  localparam int TOV = 4;
  localparam int GPV = 2;
  localparam int MXT = 3;

  int clen [2] = '{2, 4};
  int holdv[2] = '{1, 3};
  int code_tab[2][4] = '{'{3, 1, 0, 0}, '{3, 1, 2, 0}};

  // Model: m_t is the 1-based cycle count since the accepted start.
  int m_act[2], m_t[2], m_tries[2], m_done[2], m_fail[2];

  unlock_keyer u_dut0 (
    .clk_i(clk), .reset_i(rst0), .start_i(st0), .unlock_i(ul0),
    .a_o(a0), .busy_o(busy0), .done_o(done0), .fail_o(fail0), .tries_o(tries0)
  );

  unlock_keyer #(.CODE_LEN(4), .CODE(8'b11_01_10_00), .HOLD(3)) u_dut1 (
    .clk_i(clk), .reset_i(rst1), .start_i(st1), .unlock_i(ul1),
    .a_o(a1), .busy_o(busy1), .done_o(done1), .fail_o(fail1), .tries_o(tries1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int d, input bit rst, input bit st, input bit ul);
    int cl, len, per, r, k;
    cl  = clen[d] * holdv[d];
    len = cl + TOV;
    per = len + GPV;
    m_done[d] = 0;
    m_fail[d] = 0;
    if (rst) begin
      m_act[d]   = 0;
      m_tries[d] = 0;
    end else if (m_act[d] != 0) begin
      r = (m_t[d] - 1) % per;
      k = (m_t[d] - 1) / per;
      if (ul && r >= cl - 1 && r <= len - 1) begin
        m_act[d]  = 0;
        m_done[d] = 1;
      end else if (r == len - 1 && k == MXT - 1) begin
        m_act[d]  = 0;
        m_fail[d] = 1;
      end else begin
        m_t[d]++;
        m_tries[d] = (m_t[d] - 1) / per + 1;
      end
    end else if (st) begin
      m_act[d]   = 1;
      m_t[d]     = 1;
      m_tries[d] = 1;
    end
  endtask

  function automatic int exp_a(input int d);
    int cl, r;
    if (m_act[d] == 0) return 0;
    cl = clen[d] * holdv[d];
    r  = (m_t[d] - 1) % (cl + TOV + GPV);
    if (r < cl) return code_tab[d][r / holdv[d]];
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0, rst0, st0, ul0);
    model_step(1, rst1, st1, ul1);
    #1;
    chk("d0.a", a0, exp_a(0));
    chk("d0.busy", busy0, m_act[0]);
    chk("d0.done", done0, m_done[0]);
    chk("d0.fail", fail0, m_fail[0]);
    chk("d0.tries", tries0, m_tries[0]);
    chk("d1.a", a1, exp_a(1));
    chk("d1.busy", busy1, m_act[1]);
    chk("d1.done", done1, m_done[1]);
    chk("d1.fail", fail1, m_fail[1]);
    chk("d1.tries", tries1, m_tries[1]);
  endtask

  initial begin
    int nd, nf;
    int seq1[4] = '{3, 1, 2, 0};
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_t[i] = 0; m_tries[i] = 0; m_done[i] = 0; m_fail[i] = 0;
    end
    {rst0, st0, ul0, rst1, st1, ul1} = 6'b0;

    // Reset both instances.
    rst0 = 1; rst1 = 1;
    tick(); tick();
    rst0 = 0; rst1 = 0;
    chk("rst.a", a0, 0);
    chk("rst.busy", busy0, 0);
    chk("rst.tries", tries0, 0);

    // Quick success with unlock in WAIT.
    st0 = 1; tick(); st0 = 0;
    chk("t1.sym0", a0, 2'b11);
    chk("t1.busy", busy0, 1);
    tick(); chk("t1.sym1", a0, 2'b01);
    tick(); chk("t1.idle", a0, 2'b00);
    tick();
    ul0 = 1; tick(); ul0 = 0;
    chk("t1.done", done0, 1);
    chk("t1.busy_lo", busy0, 0);
    chk("t1.tries", tries0, 1);
    tick(); chk("t1.done_lo", done0, 0);
    chk("t1.tries_hold", tries0, 1);

    // Three failed attempts.
    nd = 0; nf = 0;
    for (int k = 1; k <= 24; k++) begin
      if (k == 1) begin st0 = 1; tick(); st0 = 0; end
      else tick();
      if (k == 1)  chk("t2.tries1", tries0, 1);
      if (k == 8)  chk("t2.gap_tries", tries0, 1);
      if (k == 9)  chk("t2.tries2", tries0, 2);
      if (k == 17) chk("t2.tries3", tries0, 3);
      if (k == 23) chk("t2.fail_at", fail0, 1);
      nd += int'(done0);
      nf += int'(fail0);
    end
    chk("t2.nfail", nf, 1);
    chk("t2.ndone", nd, 0);

    // Long-hold instance: symbol order/duration, unlock on 2nd symbol ignored.
    nd = 0;
    st1 = 1; tick(); st1 = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) tick();
      chk("t3.sym", a1, seq1[(k - 1) / 3]);
      ul1 = (k == 5);
      nd += int'(done1);
    end
    ul1 = 0;
    chk("t3.ndone", nd, 0);
    chk("t3.busy", busy1, 1);
    rst1 = 1; tick(); rst1 = 0;

    // Reset during WAIT of attempt 2.
    st0 = 1; tick(); st0 = 0;
    repeat (10) tick();
    chk("t4.tries_pre", tries0, 2);
    rst0 = 1; tick(); rst0 = 0;
    chk("t4.a", a0, 0);
    chk("t4.busy", busy0, 0);
    chk("t4.tries", tries0, 0);
    nd = 0; nf = 0;
    repeat (30) begin tick(); nd += int'(done0); nf += int'(fail0); end
    chk("t4.no_pulse", nd + nf, 0);

    // Start while busy is ignored.
    st0 = 1; tick(); st0 = 0;
    tick();
    st0 = 1; tick(); st0 = 0;
    chk("t5.no_restart", a0, 2'b00);
    chk("t5.tries", tries0, 1);
    nf = 0;
    repeat (21) begin tick(); nf += int'(fail0); end
    chk("t5.nfail", nf, 1);

    // Unlock on the timeout edge wins.
    st0 = 1; tick(); st0 = 0;
    repeat (5) tick();
    chk("t6.in_wait", busy0, 1);
    ul0 = 1; tick(); ul0 = 0;
    chk("t6.done", done0, 1);
    chk("t6.fail", fail0, 0);
    chk("t6.tries", tries0, 1);
    chk("t6.busy", busy0, 0);

    // Reset beats start.
    rst0 = 1; st0 = 1; tick(); rst0 = 0; st0 = 0;
    chk("t7.busy", busy0, 0);
    chk("t7.tries", tries0, 0);

    // Start accepted in the done cycle.
    st0 = 1; tick(); st0 = 0;
    repeat (2) tick();
    ul0 = 1; tick(); ul0 = 0;
    chk("t8.done", done0, 1);
    st0 = 1; tick(); st0 = 0;
    chk("t8.busy", busy0, 1);
    chk("t8.sym0", a0, 2'b11);

    // Random traffic on both instances.
    for (int c = 0; c < 800; c++) begin
      st0  = ($urandom_range(0, 3) == 0);
      ul0  = ($urandom_range(0, 5) == 0);
      rst0 = ($urandom_range(0, 80) == 0);
      st1  = ($urandom_range(0, 3) == 0);
      ul1  = ($urandom_range(0, 7) == 0);
      rst1 = ($urandom_range(0, 80) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unlock_keyer.md
# unlock_keyer

Transmit-side counterpart of the `unlock` sequence detector. On a `start` request it drives a programmed code onto the 2-bit symbol bus `a`, one symbol per `HOLD` cycles. It then waits a bounded time for the detector's `unlock` response. It retries after an idle gap, up to `MAX_TRIES` times, and reports success (`done`) or failure (`fail`). The block sits in front of `unlock`: `a` feeds the detector input, and the detector output returns on `unlock`.

## Interface
- `CODE_LEN`, 2 — number of symbols in the code (≥1)
- `CODE`, `{2'b11, 2'b01}` — packed code, 2·CODE_LEN bits; symbol 0 in the MSBs, sent first
- `IDLE_SYM`, `2'b00` — symbol driven whenever no code symbol is being sent
- `HOLD`, 1 — cycles each symbol is held (≥1)
- `TIMEOUT`, 4 — cycles to wait for `unlock` after the last symbol (≥1)
- `GAP`, 2 — idle cycles between attempts (≥1)
- `MAX_TRIES`, 3 — attempts before failure (≥1)
- `clk`  in  1  — clock, rising edge
- `reset`  in  1  — synchronous, active-high
- `start`  in  1  — request a send sequence; sampled only in IDLE
- `unlock`  in  1  — detector response
- `a`  out  2  — symbol bus to the detector, registered
- `busy`  out  1  — high in every state except IDLE
- `done`  out  1  — one-cycle pulse on success
- `fail`  out  1  — one-cycle pulse after the last failed attempt
- `tries`  out  $clog2(MAX_TRIES+1)  — attempts started in the current or last sequence

## Operation
- States:
  - IDLE: `a`=IDLE_SYM.
  - SEND: symbol index `idx` with hold counter.
  - WAIT: timeout counter.
  - GAP: gap counter; `a`=IDLE_SYM.
- IDLE → SEND on `start`=1. On this transition: `idx`=0, `tries`=1.
- SEND: `a`=CODE symbol `idx`, held for HOLD cycles, then `idx`+1. After the last symbol's final hold cycle → WAIT.
- `unlock` is honoured only in two places: during the final hold cycle of the last symbol, and in WAIT. Anywhere honoured, `unlock`=1 → IDLE with `done` pulse. Elsewhere `unlock` is ignored.
- WAIT:
  - `a`=IDLE_SYM.
  - After TIMEOUT cycles without `unlock`:
    - if `tries`==MAX_TRIES → IDLE with `fail` pulse;
    - else → GAP.
- GAP: GAP cycles, then → SEND with `idx`=0 and `tries`+1.
- `start` while `busy` is ignored and not queued.
- `tries` holds its value in IDLE until the next `start`.
- Reset:
  - All outputs and state return to their reset values at the next edge.
  - Reset values: `a`=IDLE_SYM, `busy`=0, `done`=0, `fail`=0, `tries`=0, state IDLE.
  - Reset mid-sequence aborts it; no `done` or `fail` pulse.
- `reset` and `start` in the same cycle: reset wins.
- `unlock` on the same edge the timeout expires: success wins (`done`, not `fail`/GAP).

## Timing
- All outputs are registered; no combinational input→output path.
- `start` high at edge N: at edge N+1, `busy`=1 and `a`=symbol 0.
- Symbol k is on `a` from edge N+1+k·HOLD for HOLD cycles.
- WAIT starts at edge N+1+CODE_LEN·HOLD.
- Attempt length without response: CODE_LEN·HOLD + TIMEOUT cycles. Each GAP adds GAP cycles.
- `done` or `fail` is high for exactly the one cycle after the deciding edge. In that same cycle `busy`=0 and `a`=IDLE_SYM.
- Earliest new `start` accepted: the cycle `done`/`fail` is high.
- Counter widths:
  - hold, timeout, gap: `$clog2(max(HOLD,TIMEOUT,GAP)+1)`;
  - `idx`: `$clog2(CODE_LEN)` (min 1).
- Counters never wrap. They reload on every state entry.

## Structure
- Package `unlock_pkg`:
  - symbol width constant (2);
  - `sym_t` typedef;
  - state enum (IDLE, SEND, WAIT, GAP);
  - default IDLE_SYM.
- The detector side shares `unlock_pkg` for `sym_t`.
- One natural sub-module: `unlock_tmr`, a loadable down-counter with a `zero` flag. One instance is reused for the hold, timeout and gap phases.
- The FSM and symbol mux stay in `unlock_keyer`.

## Test plan
- Default params:
  - Stimulus: reset for 2 cycles, then `start` pulse at edge N.
  - Required: `a`=11 at N+1, `a`=01 at N+2, `a`=00 from N+3.
  - Stimulus: tie `unlock` high at N+4.
  - Required: `done`=1 at N+5, `busy`=0, `tries`=1.
- `unlock` held low:
  - Three attempts of 2+4 cycles each, with 2-cycle gaps.
  - `tries` steps 1→2→3.
  - `fail` pulses once at N+23; `done` never rises.
- `HOLD`=3, `CODE_LEN`=4, `CODE`=8'b11_01_10_00:
  - each symbol is stable for exactly 3 cycles, in order 11, 01, 10, 00.
  - `unlock` pulsed during the 2nd symbol is ignored.
- Reset asserted during WAIT of attempt 2:
  - next cycle `a`=00, `busy`=0, `tries`=0;
  - no `done`/`fail`.
- Second `start` while busy:
  - no restart; the sequence continues unchanged.
- `unlock` rising on the edge the TIMEOUT expires:
  - `done` pulses;
  - no GAP, `tries` unchanged.
